xmit_arbiter: RTL and testbench

Shares the single byte-wide host transmitter among several message sources: metadata responder, ID/status responder and sample-dump readout. Grants the transmitter per message, not per byte, so messages never interleave. Paces bytes with the transmitter's idle handshake. Sits between the command decoder/sample readout blocks and the UART/SPI transmitter.

---
 rtl/xmit_arbiter.sv | 126 ++++++++++++
 tb/tb_xmit_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xmit_arbiter.sv
// Per-message arbiter that shares one byte-wide transmitter among NUM_SRC sources.
// Fixed priority (index 0 highest) at message boundaries; bytes are paced by xmit_idle.
module xmit_arbiter #(
  parameter int NUM_SRC    = 3,
  parameter int GAP_CYCLES = 4,
  parameter int GAP_W      = 4
) (
  input  logic                 clock,
  input  logic                 extReset,
  input  logic [NUM_SRC-1:0]   src_req,
  input  logic [8*NUM_SRC-1:0] src_data,
  input  logic [NUM_SRC-1:0]   src_last,
  output logic [NUM_SRC-1:0]   src_ack,
  output logic [NUM_SRC-1:0]   src_grant,
  input  logic                 xmit_idle,
  output logic                 send,
  output logic [7:0]           send_data,
  output logic                 busy
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    HOLD,
    POLL,
    GAP
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_SRC-1:0]   grant_q, grant_d;
  logic [7:0]           data_q, data_d;
  logic                 last_q, last_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [NUM_SRC-1:0]   ack;
  logic [NUM_SRC-1:0]   pick;
  logic                 req_g;
  logic [7:0]           sel_data;
  logic                 sel_last;

  // Isolate the lowest set request bit: lowest index wins.
  assign pick  = src_req & (~src_req + NUM_SRC'(1));
  assign req_g = |(src_req & grant_q);

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q[i]) begin
        sel_data = src_data[8*i +: 8];
        sel_last = src_last[i];
      end
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    data_d  = data_q;
    last_d  = last_q;
    gap_d   = gap_q;
    ack     = '0;
    case (state_q)
      IDLE: begin
        if (xmit_idle && (|src_req)) begin
          grant_d = pick;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (req_g) begin
          ack     = grant_q;
          data_d  = sel_data;
          last_d  = sel_last;
          state_d = SEND;
        end else begin
          gap_d   = GAP_W'(GAP_CYCLES);
          state_d = GAP;
        end
      end
      SEND: state_d = HOLD;
      HOLD: state_d = POLL;
      POLL: begin
        if (xmit_idle) begin
          if (last_q) begin
            gap_d   = GAP_W'(GAP_CYCLES);
            state_d = GAP;
          end else begin
            state_d = LOAD;
          end
        end
      end
      GAP: begin
        // A counter of 0 or 1 means this is the final gap cycle.
        if (gap_q <= GAP_W'(1)) state_d = IDLE;
        else                    gap_d   = gap_q - GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or posedge extReset) begin
    if (extReset) begin
      state_q <= IDLE;
      grant_q <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      last_q  <= last_d;
      gap_q   <= gap_d;
    end
  end

  assign src_ack   = ack;
  assign send      = (state_q == SEND);
  assign send_data = data_q;
  assign busy      = (state_q != IDLE);
  assign src_grant = (state_q inside {LOAD, SEND, HOLD, POLL}) ? grant_q : '0;

endmodule

// File: tb/tb_xmit_arbiter.sv
// Directed bench for xmit_arbiter: byte scoreboard, transmitter model, per-source message model.
// A second instance built with GAP_CYCLES=0 checks the single-cycle gap.
module tb_xmit_arbiter;

  localparam int NS = 3;

  logic          clock = 1'b0;
  logic          extReset = 1'b1;
  logic [NS-1:0] src_req, src_last, src_ack, src_grant;
  logic [8*NS-1:0] src_data;
  logic          xmit_idle, send, busy;
  logic [7:0]    send_data;

  logic [NS-1:0]   src_req0 = '0;
  logic [8*NS-1:0] src_data0 = {NS{8'hA5}};
  logic [NS-1:0]   src_last0 = '1;
  logic [NS-1:0]   src_ack0, src_grant0;
  logic            xmit_idle0 = 1'b1;
  logic            send0, busy0;
  logic [7:0]      send_data0;

  xmit_arbiter #(.NUM_SRC(NS), .GAP_CYCLES(4), .GAP_W(4)) dut (
    .clock(clock), .extReset(extReset), .src_req(src_req), .src_data(src_data),
    .src_last(src_last), .src_ack(src_ack), .src_grant(src_grant), .xmit_idle(xmit_idle),
    .send(send), .send_data(send_data), .busy(busy)
  );

  xmit_arbiter #(.NUM_SRC(NS), .GAP_CYCLES(0), .GAP_W(2)) dut0 (
    .clock(clock), .extReset(extReset), .src_req(src_req0), .src_data(src_data0),
    .src_last(src_last0), .src_ack(src_ack0), .src_grant(src_grant0), .xmit_idle(xmit_idle0),
    .send(send0), .send_data(send_data0), .busy(busy0)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] sb[$];
  logic [7:0] msg [NS][8];
  int  idx [NS], len [NS], cut [NS], ack_cnt [NS];
  bit  en [NS], pend [NS];
  int  tx_cnt = 0;
  int  send_cnt = 0;
  bit  force_low = 1'b0;

  assign xmit_idle = (tx_cnt == 0) && !force_low;

  always_comb begin
    src_req  = '0;
    src_last = '0;
    src_data = '0;
    for (int i = 0; i < NS; i++) begin
      src_req[i]  = en[i] && (idx[i] < len[i]) && (idx[i] < cut[i]);
      src_last[i] = (idx[i] == len[i] - 1);
      src_data[8*i +: 8] = (idx[i] < 8) ? msg[i][idx[i]] : 8'h00;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Transmitter and source models plus scoreboard pop, all mid-cycle.
  always @(negedge clock) begin
    if (extReset) begin
      tx_cnt = 0;
      for (int i = 0; i < NS; i++) pend[i] = 1'b0;
    end else begin
      if (send) begin
        int got;
        got = (sb.size() > 0);
        check("send_expected", got, 1);
        if (got != 0) check("send_data", send_data, sb.pop_front());
        tx_cnt = 8;
        send_cnt++;
      end else if (tx_cnt > 0) begin
        tx_cnt--;
      end
      for (int i = 0; i < NS; i++) begin
        if (pend[i]) begin
          idx[i]++;
          pend[i] = 1'b0;
        end
        if (src_ack[i]) begin
          pend[i] = 1'b1;
          ack_cnt[i]++;
        end
      end
    end
  end

  task automatic tick;
    @(negedge clock);
  endtask

  task automatic clear_counts;
    for (int i = 0; i < NS; i++) ack_cnt[i] = 0;
    send_cnt = 0;
  endtask

  // Bytes listed lowest first in b; only the bytes the source will offer are expected.
  task automatic start_msg(input int s, input int n, input int c, input logic [31:0] b);
    for (int k = 0; k < n; k++) msg[s][k] = b[8*k +: 8];
    len[s]  = n;
    cut[s]  = c;
    idx[s]  = 0;
    pend[s] = 1'b0;
    en[s]   = 1'b1;
    for (int k = 0; k < ((n < c) ? n : c); k++) sb.push_back(b[8*k +: 8]);
  endtask

  task automatic wait_done(input int budget, output int gaps, output int multi);
    int n;
    n = 0;
    gaps = 0;
    multi = 0;
    do begin
      tick();
      n++;
      if (busy && (src_grant == '0)) gaps++;
      if ($countones(src_grant) > 1) multi++;
    end while ((busy || (sb.size() != 0)) && (n < budget));
    check("finished_in_budget", busy, 0);
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    int gaps, multi, n;
    for (int i = 0; i < NS; i++) begin
      idx[i] = 0; len[i] = 0; cut[i] = 0; en[i] = 1'b0; pend[i] = 1'b0; ack_cnt[i] = 0;
    end

    // Reset state
    tick(); tick();
    check("rst_send", send, 0);
    check("rst_ack", src_ack, 0);
    check("rst_grant", src_grant, 0);
    check("rst_busy", busy, 0);
    check("rst_data", send_data, 0);
    extReset = 1'b0;
    tick();

    // Source 1, three bytes, first-byte latency and data hold
    clear_counts();
    start_msg(1, 3, 3, 32'h0033_2211);
    tick();
    check("t1_grant", src_grant, 3'b010);
    check("t1_ack", src_ack, 3'b010);
    check("t1_send_early", send, 0);
    tick();
    check("t2_send", send, 1);
    tick(); tick();
    check("poll_data_hold", send_data, 8'h11);
    check("poll_no_send", send, 0);
    wait_done(300, gaps, multi);
    check("msg1_acks", ack_cnt[1], 3);
    check("msg1_sends", send_cnt, 3);
    check("msg1_gap", gaps, 4);
    check("msg1_grant_end", src_grant, 0);

    // Simultaneous requests: source 1 first, then source 2 after its gap
    clear_counts();
    start_msg(1, 2, 2, 32'h0000_A2A1);
    start_msg(2, 3, 3, 32'h00B3_B2B1);
    tick();
    check("prio_grant", src_grant, 3'b010);
    wait_done(500, gaps, multi);
    check("prio_acks1", ack_cnt[1], 2);
    check("prio_acks2", ack_cnt[2], 3);
    check("prio_gaps", gaps, 8);
    check("prio_onehot", multi, 0);

    // Source 0 arrives mid-message of source 2
    clear_counts();
    start_msg(2, 4, 4, 32'hC4C3_C2C1);
    n = 0;
    while ((ack_cnt[2] < 2) && (n < 200)) begin tick(); n++; end
    check("mid_reached", ack_cnt[2] >= 2, 1);
    start_msg(0, 1, 1, 32'h0000_00D1);
    wait_done(500, gaps, multi);
    check("mid_acks2", ack_cnt[2], 4);
    check("mid_acks0", ack_cnt[0], 1);

    // Abandoned message, then a normal one
    clear_counts();
    start_msg(1, 3, 1, 32'h00E3_E2E1);
    wait_done(300, gaps, multi);
    check("abandon_sends", send_cnt, 1);
    check("abandon_acks", ack_cnt[1], 1);
    check("abandon_gap", gaps, 4);
    clear_counts();
    start_msg(1, 1, 1, 32'h0000_00F1);
    wait_done(300, gaps, multi);
    check("after_abandon_sends", send_cnt, 1);

    // Reset while in POLL, message restarts from the first byte
    clear_counts();
    start_msg(0, 2, 2, 32'h0000_2B1A);
    n = 0;
    while (!send && (n < 50)) begin tick(); n++; end
    tick(); tick();
    extReset = 1'b1;
    #1;
    check("mid_rst_send", send, 0);
    check("mid_rst_ack", src_ack, 0);
    check("mid_rst_grant", src_grant, 0);
    check("mid_rst_busy", busy, 0);
    sb.delete();
    tx_cnt = 0;
    start_msg(0, 2, 2, 32'h0000_2B1A);
    tick();
    check("rst_hold_busy", busy, 0);
    extReset = 1'b0;
    tick();
    check("restart_grant", src_grant, 3'b001);
    check("restart_ack", src_ack, 3'b001);
    tick();
    check("restart_send", send, 1);
    check("restart_data", send_data, 8'h1A);
    wait_done(300, gaps, multi);

    // Transmitter busy in IDLE blocks the grant
    clear_counts();
    force_low = 1'b1;
    start_msg(1, 1, 1, 32'h0000_0077);
    repeat (5) tick();
    check("blocked_grant", src_grant, 0);
    check("blocked_busy", busy, 0);
    force_low = 1'b0;
    tick();
    check("unblocked_grant", src_grant, 3'b010);
    wait_done(300, gaps, multi);

    // GAP_CYCLES=0 instance: single-cycle gap between back-to-back messages
    src_req0 = 3'b001;
    n = 0;
    while (!send0 && (n < 50)) begin tick(); n++; end
    check("g0_first_send", send0, 1);
    gaps = 0;
    n = 0;
    do begin
      tick();
      n++;
      if (busy0 && (src_grant0 == '0)) gaps++;
    end while (!send0 && (n < 50));
    check("g0_gap_cycles", gaps, 1);
    check("g0_period", n, 6);
    src_req0 = '0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
